// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the D-stage hazard controller.
// Contents: register/Tnew widths, the Tnew producer codes, the forwarding
// select codes, the in-flight writer record, and the saturating Tnew decrement.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned T_W   = 3;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned TU_W  = 2;

   // Tnew codes: how many stages until the produced value exists.
   localparam logic [T_W-1:0] PC_T  = T_W'(0);
   localparam logic [T_W-1:0] ALU_T = T_W'(1);
   localparam logic [T_W-1:0] DM_T  = T_W'(2);

   // Forwarding select codes.
   localparam logic [SEL_W-1:0] FWD_RF = SEL_W'(0);
   localparam logic [SEL_W-1:0] FWD_E  = SEL_W'(1);
   localparam logic [SEL_W-1:0] FWD_M  = SEL_W'(2);
   localparam logic [SEL_W-1:0] FWD_W  = SEL_W'(3);

   // In-flight writer record; a3 == 0 marks a bubble.
   typedef struct packed {
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] a3;
      logic [T_W-1:0]   tnew;
   } hz_rec_t;

   localparam hz_rec_t REC_BUBBLE = '0;

   // Tnew counts down one per stage and rests at zero.
   function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
      return (t == '0) ? '0 : t - T_W'(1);
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline record flop for the hazard controller.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset (clears the record)
//   bubble_i     - load an empty record instead of rec_i
//   dec_i        - decrement Tnew of the incoming record (saturating at 0)
//   rec_i        - record arriving from the previous stage
//   rec_o        - registered record
module hazard_stage_reg
   import hazard_ctrl_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  logic    bubble_i,
   input  logic    dec_i,
   input  hz_rec_t rec_i,
   output hz_rec_t rec_o
);

   hz_rec_t rec_d;
   hz_rec_t rec_q;

   // Next record: pass through, optionally age Tnew, or squash to a bubble.
   always_comb begin
      rec_d = rec_i;
      if (dec_i) begin
         rec_d.tnew = tnew_dec(rec_i.tnew);
      end
      if (bubble_i) begin
         rec_d = REC_BUBBLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rec_q <= REC_BUBBLE;
      end else begin
         rec_q <= rec_d;
      end
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the five-stage MIPS pipeline.
// Tracks E/M/W writer records built from the decoder's A3/Tnew and checks
// them against the D-stage instruction's Tuse flags.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   d_rs, d_rt           - D-stage source register fields
//   d_tuse_rs0/rs1       - rs needed in D (0) or E (1)
//   d_tuse_rt0/rt1/rt2   - rt needed in D (0), E (1) or M (2)
//   d_regwrite, d_a3     - D instruction writes GPR d_a3
//   d_tnew               - stages until the D instruction's result exists
//   stall                - freeze PC and IF/ID, bubble into ID/EX
//   fwd_d_rs, fwd_d_rt   - D operand select: 0=RF 1=E 2=M 3=W
//   fwd_e_rs, fwd_e_rt   - E operand select: 0=pipe reg 2=M 3=W
//   fwd_m_rt             - M store data select: 0=pipe reg 1=W
// All outputs are combinational from the records and the D inputs.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [REG_W-1:0] d_rs,
   input  logic [REG_W-1:0] d_rt,
   input  logic             d_tuse_rs0,
   input  logic             d_tuse_rs1,
   input  logic             d_tuse_rt0,
   input  logic             d_tuse_rt1,
   input  logic             d_tuse_rt2,
   input  logic             d_regwrite,
   input  logic [REG_W-1:0] d_a3,
   input  logic [T_W-1:0]   d_tnew,
   output logic             stall,
   output logic [SEL_W-1:0] fwd_d_rs,
   output logic [SEL_W-1:0] fwd_d_rt,
   output logic [SEL_W-1:0] fwd_e_rs,
   output logic [SEL_W-1:0] fwd_e_rt,
   output logic             fwd_m_rt
);

   hz_rec_t d_rec;
   hz_rec_t e_rec;
   hz_rec_t m_rec;
   hz_rec_t w_rec;

   logic            tuse_rs_vld;
   logic            tuse_rt_vld;
   logic [TU_W-1:0] tuse_rs;
   logic [TU_W-1:0] tuse_rt;
   logic [SEL_W-1:0] fwd_m_sel;

   // A source waits while a matching E/M producer needs more stages than it has.
   function automatic logic stall_hit(input logic [REG_W-1:0] r,
                                      input logic             vld,
                                      input logic [TU_W-1:0]  tuse,
                                      input hz_rec_t          x);
      return vld && (r != '0) && (x.a3 == r) && (x.tnew > T_W'(tuse));
   endfunction

   // Nearest matching stage wins; it forwards only once its value exists.
   function automatic logic [SEL_W-1:0] pick_fwd(input logic [REG_W-1:0] r,
                                                 input hz_rec_t s1, input logic [SEL_W-1:0] c1,
                                                 input hz_rec_t s2, input logic [SEL_W-1:0] c2,
                                                 input hz_rec_t s3, input logic [SEL_W-1:0] c3);
      logic [SEL_W-1:0] sel;
      sel = FWD_RF;
      if (r != '0) begin
         if (s1.a3 == r) begin
            sel = (s1.tnew == '0) ? c1 : FWD_RF;
         end else if (s2.a3 == r) begin
            sel = (s2.tnew == '0) ? c2 : FWD_RF;
         end else if (s3.a3 == r) begin
            sel = (s3.tnew == '0) ? c3 : FWD_RF;
         end
      end
      return sel;
   endfunction

   // Record for the D instruction; non-writers enter as bubbles.
   always_comb begin
      d_rec      = REC_BUBBLE;
      d_rec.rs   = d_rs;
      d_rec.rt   = d_rt;
      d_rec.a3   = d_regwrite ? d_a3 : '0;
      d_rec.tnew = d_tnew;
   end

   // Smallest Tuse wins when several flags are raised.
   always_comb begin
      tuse_rs_vld = d_tuse_rs0 | d_tuse_rs1;
      tuse_rs     = d_tuse_rs0 ? TU_W'(0) : TU_W'(1);
      tuse_rt_vld = d_tuse_rt0 | d_tuse_rt1 | d_tuse_rt2;
      tuse_rt     = d_tuse_rt0 ? TU_W'(0) : (d_tuse_rt1 ? TU_W'(1) : TU_W'(2));
   end

   // W is excluded: its Tnew is always zero by the time it gets there.
   always_comb begin
      stall = stall_hit(d_rs, tuse_rs_vld, tuse_rs, e_rec)
            | stall_hit(d_rs, tuse_rs_vld, tuse_rs, m_rec)
            | stall_hit(d_rt, tuse_rt_vld, tuse_rt, e_rec)
            | stall_hit(d_rt, tuse_rt_vld, tuse_rt, m_rec);
   end

   always_comb begin
      fwd_d_rs  = pick_fwd(d_rs, e_rec, FWD_E, m_rec, FWD_M, w_rec, FWD_W);
      fwd_d_rt  = pick_fwd(d_rt, e_rec, FWD_E, m_rec, FWD_M, w_rec, FWD_W);
      fwd_e_rs  = pick_fwd(e_rec.rs, m_rec, FWD_M, w_rec, FWD_W, REC_BUBBLE, FWD_RF);
      fwd_e_rt  = pick_fwd(e_rec.rt, m_rec, FWD_M, w_rec, FWD_W, REC_BUBBLE, FWD_RF);
      fwd_m_sel = pick_fwd(m_rec.rt, w_rec, FWD_W, REC_BUBBLE, FWD_RF, REC_BUBBLE, FWD_RF);
      fwd_m_rt  = (fwd_m_sel == FWD_W);
   end

   // W operand fields have no consumer past this point.
   logic unused_w_ops;
   assign unused_w_ops = ^{w_rec.rs, w_rec.rt};

   // E takes the D record (bubble on stall); M and W age Tnew as they advance.
   hazard_stage_reg u_stage_e (
      .clk      (clk),
      .reset_n  (reset_n),
      .bubble_i (stall),
      .dec_i    (1'b0),
      .rec_i    (d_rec),
      .rec_o    (e_rec)
   );

   hazard_stage_reg u_stage_m (
      .clk      (clk),
      .reset_n  (reset_n),
      .bubble_i (1'b0),
      .dec_i    (1'b1),
      .rec_i    (e_rec),
      .rec_o    (m_rec)
   );

   hazard_stage_reg u_stage_w (
      .clk      (clk),
      .reset_n  (reset_n),
      .bubble_i (1'b0),
      .dec_i    (1'b1),
      .rec_i    (m_rec),
      .rec_o    (w_rec)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: MIPS instruction sequences with
// hand-derived stall and forwarding expectations.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic [REG_W-1:0] d_rs = '0;
   logic [REG_W-1:0] d_rt = '0;
   logic             d_tuse_rs0 = 1'b0;
   logic             d_tuse_rs1 = 1'b0;
   logic             d_tuse_rt0 = 1'b0;
   logic             d_tuse_rt1 = 1'b0;
   logic             d_tuse_rt2 = 1'b0;
   logic             d_regwrite = 1'b0;
   logic [REG_W-1:0] d_a3 = '0;
   logic [T_W-1:0]   d_tnew = '0;
   logic             stall;
   logic [SEL_W-1:0] fwd_d_rs;
   logic [SEL_W-1:0] fwd_d_rt;
   logic [SEL_W-1:0] fwd_e_rs;
   logic [SEL_W-1:0] fwd_e_rt;
   logic             fwd_m_rt;

   int vectors = 0;
   int miscompares = 0;

   // Tuse flag vectors: {rs0, rs1, rt0, rt1, rt2}
   localparam logic [4:0] TU_NONE = 5'b00000;
   localparam logic [4:0] TU_RS0  = 5'b10000;
   localparam logic [4:0] TU_RS1  = 5'b01000;
   localparam logic [4:0] TU_RT0  = 5'b00100;
   localparam logic [4:0] TU_RT1  = 5'b00010;
   localparam logic [4:0] TU_RT2  = 5'b00001;

   hazard_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs0 (d_tuse_rs0),
      .d_tuse_rs1 (d_tuse_rs1),
      .d_tuse_rt0 (d_tuse_rt0),
      .d_tuse_rt1 (d_tuse_rt1),
      .d_tuse_rt2 (d_tuse_rt2),
      .d_regwrite (d_regwrite),
      .d_a3       (d_a3),
      .d_tnew     (d_tnew),
      .stall      (stall),
      .fwd_d_rs   (fwd_d_rs),
      .fwd_d_rt   (fwd_d_rt),
      .fwd_e_rs   (fwd_e_rs),
      .fwd_e_rt   (fwd_e_rt),
      .fwd_m_rt   (fwd_m_rt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] tu,
                        input logic rw, input logic [4:0] a3, input logic [2:0] tn);
      d_rs = rs;
      d_rt = rt;
      {d_tuse_rs0, d_tuse_rs1, d_tuse_rt0, d_tuse_rt1, d_tuse_rt2} = tu;
      d_regwrite = rw;
      d_a3 = a3;
      d_tnew = tn;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, TU_NONE, 1'b0, 5'd0, PC_T);
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 3'($urandom_range(0, 2)));
         vectors++;
         if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs cyc%0d: got %b want 0", i,
                     {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt});
         end
         tick();
      end
      nop();
      reset_n = 1'b1;
      tick();
      vectors++;
      if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_release: got %b want 0", {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt});
      end
   endtask

   // lw $8 ; addu $9,$8,$8
   task automatic test_load_use_alu();
      flush();
      drive(5'd29, 5'd8, TU_RS1, 1'b1, 5'd8, DM_T);
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_alu_lw_issue stall: got %b want 0", stall); end
      tick();
      drive(5'd8, 5'd8, TU_RS1 | TU_RT1, 1'b1, 5'd9, ALU_T);
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_alu_cyc1 stall: got %b want 1", stall); end
      tick();
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_alu_cyc2 stall: got %b want 0", stall); end
      vectors++;
      if (fwd_d_rs !== FWD_RF) begin miscompares++; $display("FAIL lu_alu_cyc2 fwd_d_rs: got %0d want 0", fwd_d_rs); end
      tick();
      nop();
      vectors++;
      if (fwd_e_rs !== FWD_W) begin miscompares++; $display("FAIL lu_alu_e fwd_e_rs: got %0d want 3", fwd_e_rs); end
      vectors++;
      if (fwd_e_rt !== FWD_W) begin miscompares++; $display("FAIL lu_alu_e fwd_e_rt: got %0d want 3", fwd_e_rt); end
   endtask

   // lw $8 ; beq $8,$8
   task automatic test_load_use_branch();
      flush();
      drive(5'd29, 5'd8, TU_RS1, 1'b1, 5'd8, DM_T);
      tick();
      drive(5'd8, 5'd8, TU_RS0 | TU_RT0, 1'b0, 5'd0, PC_T);
      for (int c = 1; c <= 2; c++) begin
         vectors++;
         if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_beq_cyc%0d stall: got %b want 1", c, stall); end
         tick();
      end
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_beq_cyc3 stall: got %b want 0", stall); end
      vectors++;
      if (fwd_d_rs !== FWD_W) begin miscompares++; $display("FAIL lu_beq_cyc3 fwd_d_rs: got %0d want 3", fwd_d_rs); end
      vectors++;
      if (fwd_d_rt !== FWD_W) begin miscompares++; $display("FAIL lu_beq_cyc3 fwd_d_rt: got %0d want 3", fwd_d_rt); end
   endtask

   // ori $5,$0,imm ; beq $5,$5
   task automatic test_alu_branch();
      flush();
      drive(5'd0, 5'd5, TU_RS1, 1'b1, 5'd5, ALU_T);
      tick();
      drive(5'd5, 5'd5, TU_RS0 | TU_RT0, 1'b0, 5'd0, PC_T);
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL ori_beq_cyc1 stall: got %b want 1", stall); end
      tick();
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL ori_beq_cyc2 stall: got %b want 0", stall); end
      vectors++;
      if (fwd_d_rs !== FWD_M) begin miscompares++; $display("FAIL ori_beq_cyc2 fwd_d_rs: got %0d want 2", fwd_d_rs); end
      vectors++;
      if (fwd_d_rt !== FWD_M) begin miscompares++; $display("FAIL ori_beq_cyc2 fwd_d_rt: got %0d want 2", fwd_d_rt); end
   endtask

   // jal ; jr $31, then jal ; jal ; jr $31 for E-over-M and M-over-W priority
   task automatic test_jal_jr();
      flush();
      drive(5'd0, 5'd0, TU_NONE, 1'b1, 5'd31, PC_T);
      tick();
      drive(5'd31, 5'd0, TU_RS0, 1'b0, 5'd0, PC_T);
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL jal_jr stall: got %b want 0", stall); end
      vectors++;
      if (fwd_d_rs !== FWD_E) begin miscompares++; $display("FAIL jal_jr fwd_d_rs: got %0d want 1", fwd_d_rs); end
      flush();
      drive(5'd0, 5'd0, TU_NONE, 1'b1, 5'd31, PC_T);
      tick();
      tick();
      drive(5'd31, 5'd0, TU_RS0, 1'b0, 5'd0, PC_T);
      vectors++;
      if (fwd_d_rs !== FWD_E) begin miscompares++; $display("FAIL jal2_jr fwd_d_rs: got %0d want 1", fwd_d_rs); end
      tick();
      nop();
      vectors++;
      if (fwd_e_rs !== FWD_M) begin miscompares++; $display("FAIL jal2_jr fwd_e_rs: got %0d want 2", fwd_e_rs); end
   endtask

   // addu $0,$1,$2 ; beq $0,$0 -- register 0 is never a hazard
   task automatic test_zero_reg();
      flush();
      drive(5'd1, 5'd2, TU_RS1 | TU_RT1, 1'b1, 5'd0, ALU_T);
      tick();
      drive(5'd0, 5'd0, TU_RS0 | TU_RT0, 1'b0, 5'd0, PC_T);
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin
            miscompares++;
            $display("FAIL zero_reg cyc%0d: got stall=%b fwd_d_rs=%0d fwd_d_rt=%0d want 0", c, stall, fwd_d_rs, fwd_d_rt);
         end
         tick();
      end
   endtask

   // lw $4 ; sw $4,0($29)
   task automatic test_store_fwd();
      flush();
      drive(5'd29, 5'd4, TU_RS1, 1'b1, 5'd4, DM_T);
      tick();
      drive(5'd29, 5'd4, TU_RS1 | TU_RT2, 1'b0, 5'd0, PC_T);
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL sw_d stall: got %b want 0", stall); end
      vectors++;
      if (fwd_d_rt !== FWD_RF) begin miscompares++; $display("FAIL sw_d fwd_d_rt: got %0d want 0", fwd_d_rt); end
      tick();
      nop();
      vectors++;
      if (fwd_e_rt !== FWD_RF) begin miscompares++; $display("FAIL sw_e fwd_e_rt: got %0d want 0", fwd_e_rt); end
      tick();
      vectors++;
      if (fwd_m_rt !== 1'b1) begin miscompares++; $display("FAIL sw_m fwd_m_rt: got %b want 1", fwd_m_rt); end
      tick();
      vectors++;
      if (fwd_m_rt !== 1'b0) begin miscompares++; $display("FAIL sw_gone fwd_m_rt: got %b want 0", fwd_m_rt); end
   endtask

   // lw $8 ; beq $8 interrupted by reset, then beq re-issued
   task automatic test_reset_mid_stall();
      flush();
      drive(5'd29, 5'd8, TU_RS1, 1'b1, 5'd8, DM_T);
      tick();
      drive(5'd8, 5'd8, TU_RS0 | TU_RT0, 1'b0, 5'd0, PC_T);
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_mid pre stall: got %b want 1", stall); end
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin
         miscompares++;
         $display("FAIL rst_mid during: got stall=%b fwd_d_rs=%0d fwd_d_rt=%0d want 0", stall, fwd_d_rs, fwd_d_rt);
      end
      tick();
      reset_n = 1'b1;
      drive(5'd8, 5'd8, TU_RS0 | TU_RT0, 1'b0, 5'd0, PC_T);
      vectors++;
      if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin
         miscompares++;
         $display("FAIL rst_mid reissue: got stall=%b fwd_d_rs=%0d fwd_d_rt=%0d want 0", stall, fwd_d_rs, fwd_d_rt);
      end
      tick();
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_mid after stall: got %b want 0", stall); end
   endtask

   initial begin
      test_reset();
      test_load_use_alu();
      test_load_use_branch();
      test_alu_branch();
      test_jal_jr();
      test_zero_reg();
      test_store_fwd();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
